// File: rtl/mbist_march_ctrl_if.sv
// rtl/mbist_march_ctrl_if.sv - controller-to-memory and control/status bundle for the March C- BIST
interface mbist_march_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  fail;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic [2:0]            fail_elem;
    logic                  write_read;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        input  start, rdata,
        output busy, done, fail, fail_addr, fail_elem, write_read, address, wdata
    );

    modport slave (
        output start, rdata,
        input  busy, done, fail, fail_addr, fail_elem, write_read, address, wdata
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- memory BIST controller with 2-cycle read compare pipeline
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LAST_ADDR  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    mbist_march_ctrl_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    state_t                state, state_next;
    logic [2:0]            elem;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  phase;      // two-op elements: 0 = read slot, 1 = write slot
    logic                  drain_cnt;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Compare pipeline: stage 0 holds the read issued last cycle, stage 1 is compared now
    logic                  v0, v1;
    logic [DATA_WIDTH-1:0] exp0, exp1;
    logic [ADDR_WIDTH-1:0] pa0, pa1;
    logic [2:0]            pe0, pe1;
    logic                  fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [2:0]            fail_elem_q;

    logic                  elem_down, elem_two, at_end, last_op, rd_op;
    logic [DATA_WIDTH-1:0] rd_exp;
    logic [2:0]            nxt_elem;
    logic [ADDR_WIDTH-1:0] nxt_first;
    logic [DATA_WIDTH-1:0] nxt_wval;

    assign elem_down = (elem == 3'd3) || (elem == 3'd4);
    assign elem_two  = (elem >= 3'd1) && (elem <= 3'd4);
    assign at_end    = elem_down ? (addr == '0) : (addr == LAST);
    assign last_op   = at_end && (!elem_two || phase);
    assign rd_op     = (state == S_RUN) && (elem != 3'd0) && !(elem_two && phase);
    assign rd_exp    = ((elem == 3'd2) || (elem == 3'd4)) ? ONES : '0;
    assign nxt_elem  = elem + 3'd1;
    assign nxt_first = ((nxt_elem == 3'd3) || (nxt_elem == 3'd4)) ? LAST : '0;
    assign nxt_wval  = ((nxt_elem == 3'd1) || (nxt_elem == 3'd3)) ? ONES : '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start) state_next = S_SETUP;
            S_SETUP: state_next = S_RUN;
            S_RUN:   if (last_op) state_next = (elem == 3'd5) ? S_DRAIN : S_SETUP;
            S_DRAIN: if (drain_cnt) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Memory op and status outputs; SETUP and the read slots issue reads
    always_comb begin
        bus.busy       = (state == S_SETUP) || (state == S_RUN) || (state == S_DRAIN);
        bus.done       = (state == S_DONE);
        bus.write_read = (state == S_RUN) && ((elem == 3'd0) || (elem_two && phase));
        bus.address    = ((state == S_SETUP) || (state == S_RUN)) ? addr : '0;
    end

    assign bus.wdata     = wdata_q;
    assign bus.fail      = fail_q;
    assign bus.fail_addr = fail_addr_q;
    assign bus.fail_elem = fail_elem_q;

    // Element/address sequencing; wdata is loaded on element entry and held throughout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem      <= 3'd0;
            addr      <= '0;
            phase     <= 1'b0;
            drain_cnt <= 1'b0;
            wdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    elem    <= 3'd0;
                    addr    <= '0;
                    phase   <= 1'b0;
                    wdata_q <= '0;
                end
                S_RUN: begin
                    if (last_op) begin
                        phase     <= 1'b0;
                        drain_cnt <= 1'b0;
                        if (elem != 3'd5) begin
                            elem    <= nxt_elem;
                            addr    <= nxt_first;
                            wdata_q <= nxt_wval;
                        end
                    end else if (elem_two && !phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        addr  <= elem_down ? addr - ONE : addr + ONE;
                    end
                end
                S_DRAIN: drain_cnt <= 1'b1;
                S_DONE:  addr <= '0;
                default: ;
            endcase
        end
    end

    // Read-compare pipeline and sticky first-failure capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0; exp0 <= '0; pa0 <= '0; pe0 <= 3'd0;
            v1 <= 1'b0; exp1 <= '0; pa1 <= '0; pe1 <= 3'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
        end else begin
            v0 <= rd_op; exp0 <= rd_exp; pa0 <= addr; pe0 <= elem;
            v1 <= v0;    exp1 <= exp0;   pa1 <= pa0;  pe1 <= pe0;
            if (state == S_IDLE && bus.start) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_elem_q <= 3'd0;
            end else if (v1 && (bus.rdata != exp1) && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= pa1;
                fail_elem_q <= pe1;
            end
        end
    end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - randomized self-checking bench for mbist_march_ctrl
module tb_mbist_march_ctrl;
    localparam int L       = 3;
    localparam int N       = L + 1;
    localparam int RUN_CYC = 10 * N + 8;

    typedef struct {
        bit         setup;
        bit         wr;
        int         addr;
        logic [7:0] data;
        int         elem;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mbist_march_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LAST_ADDR(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    op_t        trace[$];
    logic [7:0] mem[16];
    logic [7:0] p1, p2;
    logic [7:0] corr[6][4];
    logic [7:0] wlog[4][$];
    int         wr_addr_log[$];
    int         checks = 0;
    int         errors = 0;

    // Reference op sequence from the March C- element list
    function automatic void build_trace();
        trace.delete();
        for (int e = 0; e < 6; e++) begin
            bit         down;
            logic [7:0] wv, rv;
            down = (e == 3) || (e == 4);
            wv   = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            rv   = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            trace.push_back('{1'b1, 1'b0, down ? L : 0, wv, e});
            for (int k = 0; k < N; k++) begin
                int a;
                a = down ? L - k : k;
                if (e == 0)      trace.push_back('{1'b0, 1'b1, a, wv, e});
                else if (e == 5) trace.push_back('{1'b0, 1'b0, a, rv, e});
                else begin
                    trace.push_back('{1'b0, 1'b0, a, rv, e});
                    trace.push_back('{1'b0, 1'b1, a, wv, e});
                end
            end
        end
    endfunction

    task automatic clear_corr();
        for (int e = 0; e < 6; e++)
            for (int a = 0; a < 4; a++) corr[e][a] = 8'h00;
    endtask

    // Behavioural memory with 2-cycle read latency, sampled at the falling edge
    task automatic mem_step(input logic [7:0] mask);
        logic [7:0] nv;
        int a;
        nv = p2;
        p2 = p1;
        a  = int'(bus.address);
        if (bus.write_read) begin
            mem[a] = bus.wdata;
            if (a < 4) wlog[a].push_back(bus.wdata);
            wr_addr_log.push_back(a);
            p1 = 8'h00;
        end else begin
            p1 = mem[a] ^ mask;
        end
        bus.rdata = nv;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One full test from the start edge to the IDLE cycle after DONE
    task automatic run_body(input bit pulse, input bit hold, input string tag);
        bit         exp_fail;
        logic [3:0] exp_addr;
        logic [2:0] exp_elem;
        logic [7:0] mask;
        exp_fail = 1'b0; exp_addr = '0; exp_elem = '0;
        foreach (trace[i])
            if (!exp_fail && !trace[i].setup && !trace[i].wr &&
                corr[trace[i].elem][trace[i].addr] != 8'h00) begin
                exp_fail = 1'b1;
                exp_addr = 4'(trace[i].addr);
                exp_elem = 3'(trace[i].elem);
            end
        for (int i = 0; i < RUN_CYC; i++) begin
            tick();
            mask = 8'h00;
            if (i < trace.size() && !trace[i].setup && !trace[i].wr)
                mask = corr[trace[i].elem][trace[i].addr];
            mem_step(mask);
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s busy/done cyc %0d: got %b/%b want 1/0", tag, i, bus.busy, bus.done);
            end
            if (i == 0) begin
                checks++;
                if (bus.fail !== 1'b0) begin
                    errors++;
                    $display("FAIL %s fail_clear_at_setup: got %b want 0", tag, bus.fail);
                end
            end
            if (i < trace.size()) begin
                checks++;
                if (bus.write_read !== trace[i].wr || int'(bus.address) != trace[i].addr) begin
                    errors++;
                    $display("FAIL %s op cyc %0d: got wr=%b addr=%0d want wr=%b addr=%0d",
                             tag, i, bus.write_read, bus.address, trace[i].wr, trace[i].addr);
                end
                if (trace[i].elem != 5) begin
                    checks++;
                    if (bus.wdata !== trace[i].data && (trace[i].setup || trace[i].wr)) begin
                        errors++;
                        $display("FAIL %s wdata cyc %0d: got %h want %h", tag, i, bus.wdata, trace[i].data);
                    end
                end
            end else begin
                checks++;
                if (bus.write_read !== 1'b0) begin
                    errors++;
                    $display("FAIL %s drain_no_write cyc %0d: got %b want 0", tag, i, bus.write_read);
                end
            end
            if (!hold) bus.start = pulse ? 1'($urandom % 2) : 1'b0;
        end
        tick();
        mem_step(8'h00);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_at_%0d: got done=%b busy=%b want 1/0", tag, RUN_CYC, bus.done, bus.busy);
        end
        checks++;
        if (bus.fail !== exp_fail || (exp_fail && (bus.fail_addr !== exp_addr || bus.fail_elem !== exp_elem))) begin
            errors++;
            $display("FAIL %s result: got fail=%b addr=%0d elem=%0d want fail=%b addr=%0d elem=%0d",
                     tag, bus.fail, bus.fail_addr, bus.fail_elem, exp_fail, exp_addr, exp_elem);
        end
        checks++;
        if (bus.write_read !== 1'b0 || bus.address !== 4'd0) begin
            errors++;
            $display("FAIL %s done_op: got wr=%b addr=%0d want 0/0", tag, bus.write_read, bus.address);
        end
        bus.start = hold;
        tick();
        mem_step(8'h00);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.write_read !== 1'b0 || bus.address !== 4'd0) begin
            errors++;
            $display("FAIL %s idle_after_done: got done=%b busy=%b wr=%b addr=%0d want all 0",
                     tag, bus.done, bus.busy, bus.write_read, bus.address);
        end
        checks++;
        if (bus.fail !== exp_fail || (exp_fail && bus.fail_addr !== exp_addr)) begin
            errors++;
            $display("FAIL %s fail_hold_idle: got %b/%0d want %b/%0d", tag, bus.fail, bus.fail_addr, exp_fail, exp_addr);
        end
    endtask

    task automatic start_test(input bit pulse, input string tag);
        bus.start = 1'b1;
        run_body(pulse, 1'b0, tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.fail, bus.write_read} !== 4'b0 ||
            bus.fail_addr !== 4'd0 || bus.fail_elem !== 3'd0 || bus.address !== 4'd0 || bus.wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b fail=%b wr=%b addr=%0d wdata=%h want all 0",
                     bus.busy, bus.done, bus.fail, bus.write_read, bus.address, bus.wdata);
        end
        tick();
        rst_n = 1'b1;
        tick();
        mem_step(8'h00);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_wait: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_fault_e1();
        clear_corr();
        corr[1][2] = 8'h01;
        start_test(1'b0, "fault_e1");
    endtask

    task automatic test_first_kept();
        clear_corr();
        corr[3][1] = 8'h5A;
        corr[5][0] = 8'hFF;
        start_test(1'b0, "first_kept");
    endtask

    task automatic test_clean_after_fail();
        clear_corr();
        start_test(1'b0, "clean_after_fail");
    endtask

    task automatic test_op_trace();
        logic [7:0] exp_seq[5];
        int         exp_addr_seq[$];
        exp_seq = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        for (int a = 0; a < 4; a++) wlog[a].delete();
        wr_addr_log.delete();
        clear_corr();
        start_test(1'b0, "op_trace");
        for (int a = 0; a < 4; a++) begin
            checks++;
            if (wlog[a].size() != 5) begin
                errors++;
                $display("FAIL write_count addr %0d: got %0d want 5", a, wlog[a].size());
            end else begin
                for (int k = 0; k < 5; k++) begin
                    checks++;
                    if (wlog[a][k] !== exp_seq[k]) begin
                        errors++;
                        $display("FAIL write_order addr %0d #%0d: got %h want %h", a, k, wlog[a][k], exp_seq[k]);
                    end
                end
            end
        end
        for (int e = 0; e < 5; e++)
            for (int k = 0; k < N; k++) exp_addr_seq.push_back((e == 3 || e == 4) ? L - k : k);
        checks++;
        if (wr_addr_log != exp_addr_seq) begin
            errors++;
            $display("FAIL write_addr_seq: got %p want %p", wr_addr_log, exp_addr_seq);
        end
    endtask

    task automatic test_random_faults();
        for (int r = 0; r < 6; r++) begin
            int nf;
            clear_corr();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++)
                corr[$urandom_range(1, 5)][$urandom_range(0, L)] = 8'($urandom_range(1, 255));
            start_test(1'b0, "random_faults");
        end
    endtask

    task automatic test_reset_mid();
        int k, writes;
        clear_corr();
        k = $urandom_range(15, 22);
        bus.start = 1'b1;
        for (int i = 0; i <= k; i++) begin
            tick();
            mem_step(8'h00);
            bus.start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.fail, bus.write_read} !== 4'b0 || bus.address !== 4'd0 || bus.wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b fail=%b wr=%b addr=%0d wdata=%h want all 0",
                     bus.busy, bus.done, bus.fail, bus.write_read, bus.address, bus.wdata);
        end
        writes = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.write_read) writes++;
            mem_step(8'h00);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.write_read || bus.busy) writes++;
            mem_step(8'h00);
        end
        checks++;
        if (writes != 0) begin
            errors++;
            $display("FAIL reset_mid_no_activity: got %0d active cycles want 0", writes);
        end
        start_test(1'b0, "after_reset");
    endtask

    task automatic test_start_ignored();
        clear_corr();
        corr[4][3] = 8'h80;
        start_test(1'b1, "start_pulses");
    endtask

    task automatic test_back_to_back();
        clear_corr();
        bus.start = 1'b1;
        run_body(1'b0, 1'b1, "b2b_first");
        corr[2][0] = 8'h10;
        run_body(1'b0, 1'b1, "b2b_second");
        clear_corr();
        run_body(1'b0, 1'b0, "b2b_third");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.rdata = 8'h00;
        p1 = 8'h00;
        p2 = 8'h00;
        for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
        clear_corr();
        build_trace();
        test_reset();
        test_fault_e1();
        test_clean_after_fail();
        test_first_kept();
        test_op_trace();
        test_random_faults();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
